button_push_conditioner: RTL and testbench
==========================================

Name: button_push_conditioner

Overview:
Conditions a raw mechanical push-button into the clean, single-cycle `push` strobe that the LED toggle FSM consumes. It synchronizes the asynchronous pad input, debounces it with a stable-count state machine, and emits one-cycle press, release and long-press strobes plus a debounced level. It sits between the board button pin and every push-driven control FSM, on the single-ended system clock.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on btn_raw (legal range ≥2).
DEBOUNCE_CYCLES, 2000000, consecutive stable synchronized samples required to accept a level change (10 ms at 200 MHz; legal range ≥1).
LONG_PRESS_CYCLES, 200000000, cycles held after `push` before `long_press` fires (0 disables long_press).
ACTIVE_LOW, 0, 1 = btn_raw is low when pressed (inverted before synchronizer).

Ports:
clk  input  1  system clock, single-ended
rst  input  1  reset, synchronous, active-high
btn_raw  input  1  asynchronous button pad input
push  output  1  one-cycle strobe on accepted press
release  output  1  one-cycle strobe on accepted release
long_press  output  1  one-cycle strobe, once per press, after LONG_PRESS_CYCLES held
btn_level  output  1  debounced pressed level

Behaviour:
- Reset (sync, rst high at a clk edge):
  - state = RELEASED; deb_cnt = 0; hold_cnt = 0; long_done = 0.
  - Synchronizer flops load the not-pressed level.
  - push, release, long_press and btn_level are all 0 from the cycle after that edge.
  - rst mid-debounce or mid-press aborts with no strobe emitted.
- s = synchronized, polarity-corrected button (1 = pressed).
- All outputs are registered; each strobe is high for exactly one cycle.
- FSM states: RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
- RELEASED: s=1 -> DB_PRESS, deb_cnt<=0.
- DB_PRESS:
  - s=0 -> RELEASED (bounce rejected, no strobe).
  - Else if deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED, push<=1, hold_cnt<=0, long_done<=0.
  - Else deb_cnt++.
- PRESSED:
  - s=0 -> DB_RELEASE, deb_cnt<=0.
  - Else if LONG_PRESS_CYCLES≠0, !long_done and hold_cnt == LONG_PRESS_CYCLES-1 -> long_press<=1, long_done<=1.
  - Else hold_cnt++ while !long_done.
- DB_RELEASE:
  - s=1 -> PRESSED (bounce; no new push, hold_cnt frozen then resumes).
  - Else if deb_cnt == DEBOUNCE_CYCLES-1 -> RELEASED, release<=1.
  - Else deb_cnt++.
- btn_level = 1 in PRESSED and DB_RELEASE; 0 otherwise. It is registered alongside the state.
- Latency: with btn_raw first sampled pressed at edge 0 and stable, push is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release is symmetric.
- long_press is high in the cycle after the LONG_PRESS_CYCLES-th edge following the edge that raised push.
- Counter widths: deb_cnt = $clog2(DEBOUNCE_CYCLES+1); hold_cnt = $clog2(LONG_PRESS_CYCLES+1), min 1.
- No counter wraps: counts stop at terminal, and hold_cnt stops once long_done is set.
- push and release never assert in the same cycle. long_press never coincides with push (requires ≥1 cycle in PRESSED).
- Button held indefinitely gives exactly one push and at most one long_press.

Decomposition:
- Shared package button_pkg: FSM state encodings (RELEASED=2'd0, DB_PRESS=2'd1, PRESSED=2'd2, DB_RELEASE=2'd3) and a default-debounce constant reused by other push-driven blocks.
- One sub-module: bit_synchronizer (parameter STAGES, sync active-high rst, reset value parameter). It is instantiated once for btn_raw.

Test Plan:
- Clean press: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16; btn_raw 0->1 sampled at edge 0 -> push=1 only in the cycle after edge 6; btn_level=1 from the same cycle; no other strobe.
- Bounce rejection: btn_raw 1 for 3 cycles, 0 for 1, then 1 stable -> push fires 6 edges after the final rising sample; exactly one push total.
- Long press: hold 40 cycles after push -> exactly one long_press, in the cycle after the 16th edge following the push edge; none afterwards. Release -> release pulses once, 6 edges after the falling sample.
- Release bounce: while PRESSED, btn_raw 0 for 2 cycles then 1 -> no release, no second push, btn_level stays 1.
- Reset mid-operation: assert rst during DB_PRESS (deb_cnt=2) -> all outputs 0 next cycle, no push. Deassert with button held -> full debounce restarts and push arrives 6 edges after the first post-reset sample.
- ACTIVE_LOW=1: idle btn_raw=1, drive 0 stable -> push after 6 edges. LONG_PRESS_CYCLES=0 -> long_press never asserts over 100 held cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for push-button conditioning and the push-driven FSMs.
//   btn_state_e             : debounce FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms stable time at 200 MHz
//   cnt_width()             : bits needed to hold 0..max_val, never below 1
package button_pkg;

   typedef enum logic [1:0] {
      RELEASED   = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } btn_state_e;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2000000;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output, STAGES clocks of latency
module bit_synchronizer #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift chain; all flops return to the idle level on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_push_conditioner.sv
// Push-button conditioner: synchronizes, debounces and strobes a raw button.
//   clk, rst   : system clock, synchronous active-high reset
//   btn_raw    : asynchronous button pad input
//   push       : one-cycle strobe on accepted press
//   release_o  : one-cycle strobe on accepted release
//   long_press : one-cycle strobe once per press after LONG_PRESS_CYCLES held
//   btn_level  : debounced pressed level
module button_push_conditioner
   import button_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_PRESS_CYCLES = 200000000,
   parameter bit          ACTIVE_LOW        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic push,
   output logic release_o,
   output logic long_press,
   output logic btn_level
);

   localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W  = cnt_width(LONG_PRESS_CYCLES);
   localparam bit          LONG_EN = (LONG_PRESS_CYCLES != 0);
   localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_TERM =
      HOLD_W'(LONG_EN ? (LONG_PRESS_CYCLES - 1) : 0);

   btn_state_e        state_q;
   logic [DEB_W-1:0]  deb_q;
   logic [HOLD_W-1:0] hold_q;
   logic              long_done_q;
   logic              push_q;
   logic              release_q;
   logic              long_press_q;
   logic              level_q;
   logic              btn_pressed;
   logic              s;

   // Polarity is fixed before the synchronizer so its idle level is always 0.
   assign btn_pressed = btn_raw ^ ACTIVE_LOW;

   bit_synchronizer #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (btn_pressed),
      .q_o (s)
   );

   // Debounce FSM; strobes default low and pulse for a single cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RELEASED;
         deb_q        <= '0;
         hold_q       <= '0;
         long_done_q  <= 1'b0;
         push_q       <= 1'b0;
         release_q    <= 1'b0;
         long_press_q <= 1'b0;
         level_q      <= 1'b0;
      end else begin
         push_q       <= 1'b0;
         release_q    <= 1'b0;
         long_press_q <= 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (s) begin
                  state_q <= DB_PRESS;
                  deb_q   <= '0;
               end
            end
            DB_PRESS: begin
               if (!s) begin
                  state_q <= RELEASED;
               end else if (deb_q == DEB_TERM) begin
                  state_q     <= PRESSED;
                  push_q      <= 1'b1;
                  level_q     <= 1'b1;
                  hold_q      <= '0;
                  long_done_q <= 1'b0;
               end else begin
                  deb_q <= deb_q + DEB_W'(1);
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_q <= DB_RELEASE;
                  deb_q   <= '0;
               end else if (LONG_EN && !long_done_q && (hold_q == HOLD_TERM)) begin
                  long_press_q <= 1'b1;
                  long_done_q  <= 1'b1;
               end else if (LONG_EN && !long_done_q) begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            DB_RELEASE: begin
               // A bounce back to pressed resumes the hold count where it stopped.
               if (s) begin
                  state_q <= PRESSED;
               end else if (deb_q == DEB_TERM) begin
                  state_q   <= RELEASED;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  deb_q <= deb_q + DEB_W'(1);
               end
            end
         endcase
      end
   end

   assign push       = push_q;
   assign release_o  = release_q;
   assign long_press = long_press_q;
   assign btn_level  = level_q;

endmodule

// File: tb/tb_button_push_conditioner.sv
// Bench for button_push_conditioner: segment table plus strobe scoreboard.
module tb_button_push_conditioner;

   typedef enum int {K_PUSH = 0, K_REL = 1, K_LONG = 2, K_NONE = 3} kind_e;

   typedef struct {
      string name;
      int    dut;
      bit    rst;
      bit    btn;
      int    len;
      kind_e kind;
      int    off;
      bit    lvl;
   } seg_t;

   typedef struct {
      int    dut;
      kind_e kind;
      int    at;
   } ev_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic btn_a = 1'b0;
   logic btn_b = 1'b1;
   logic push_a, rel_a, long_a, lvl_a;
   logic push_b, rel_b, long_b, lvl_b;
   logic [2:0] st_a, st_b, sv;

   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;
   ev_t  exp_q[$];
   seg_t tbl[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   button_push_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .clk(clk), .rst(rst), .btn_raw(btn_a),
      .push(push_a), .release_o(rel_a), .long_press(long_a), .btn_level(lvl_a)
   );

   button_push_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(0), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .rst(rst), .btn_raw(btn_b),
      .push(push_b), .release_o(rel_b), .long_press(long_b), .btn_level(lvl_b)
   );

   assign st_a = {long_a, rel_a, push_a};
   assign st_b = {long_b, rel_b, push_b};

   task automatic see_event(input int d, input kind_e k, input int t);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL strobe: got dut%0d %s at edge %0d, required no strobe", d, k.name(), t);
      end else begin
         e = exp_q.pop_front();
         if (e.dut != d || e.kind != k || e.at != t) begin
            errors++;
            $display("FAIL strobe: got dut%0d %s at edge %0d, required dut%0d %s at edge %0d",
                     d, k.name(), t, e.dut, e.kind.name(), e.at);
         end
      end
   endtask

   // Every strobe seen on either DUT must match the head of the scoreboard.
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         sv = (d == 0) ? st_a : st_b;
         for (int k = 0; k < 3; k++)
            if (sv[k] === 1'b1) see_event(d, kind_e'(k), edge_n - 1);
      end
   end

   task automatic expect_ev(input int d, input kind_e k, input int at);
      ev_t e;
      e.dut = d; e.kind = k; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic check_lvl(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: btn_level got %b required %b", name, got, req);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic add(input string n, input int d, input bit r, input bit b,
                      input int len, input kind_e k, input int off, input bit lvl);
      seg_t v;
      v.name = n; v.dut = d; v.rst = r; v.btn = b;
      v.len = len; v.kind = k; v.off = off; v.lvl = lvl;
      tbl.push_back(v);
   endtask

   // Hold inputs for v.len edges; the expected strobe is relative to the first edge.
   task automatic apply(input seg_t v);
      for (int i = 0; i < v.len; i++) begin
         @(negedge clk);
         rst = v.rst;
         if (v.dut == 0) begin btn_a = v.btn; btn_b = 1'b1; end
         else            begin btn_b = v.btn; btn_a = 1'b0; end
         if (i == 0 && v.kind != K_NONE) expect_ev(v.dut, v.kind, edge_n + v.off);
      end
      @(posedge clk); #2;
      check_lvl(v.name, (v.dut == 0) ? lvl_a : lvl_b, v.lvl);
   endtask

   task automatic wait_for(input string name, input int d, input int k, input int budget,
                           output int at, output bit ok);
      logic [2:0] w;
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #2;
         w = (d == 0) ? st_a : st_b;
         if (w[k] === 1'b1) begin ok = 1'b1; at = edge_n - 1; end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: no strobe within %0d cycles, required one", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, p_at, l_at, r_at;
      bit ok;

      add("reset",           0, 1, 0,   3, K_NONE, 0,  0);
      add("clean_press",     0, 0, 1,  10, K_PUSH, 6,  1);
      add("long_hold",       0, 0, 1,  40, K_LONG, 12, 1);
      add("rel_bounce_low",  0, 0, 0,   2, K_NONE, 0,  1);
      add("rel_bounce_back", 0, 0, 1,   8, K_NONE, 0,  1);
      add("release",         0, 0, 0,  10, K_REL,  6,  0);
      add("bounce_hi",       0, 0, 1,   3, K_NONE, 0,  0);
      add("bounce_lo",       0, 0, 0,   1, K_NONE, 0,  0);
      add("bounce_settle",   0, 0, 1,  10, K_PUSH, 6,  1);
      add("release2",        0, 0, 0,  10, K_REL,  6,  0);
      add("pre_reset_db",    0, 0, 1,   5, K_NONE, 0,  0);
      add("reset_in_db",     0, 1, 1,   1, K_NONE, 0,  0);
      add("restart_press",   0, 0, 1,  10, K_PUSH, 6,  1);
      add("reset_pressed",   0, 1, 1,   1, K_NONE, 0,  0);
      add("quiet_after_rst", 0, 0, 0,   8, K_NONE, 0,  0);
      add("al_idle",         1, 0, 1,   4, K_NONE, 0,  0);
      add("al_press_hold",   1, 0, 0, 110, K_PUSH, 6,  1);
      add("al_release",      1, 0, 1,  10, K_REL,  6,  0);

      foreach (tbl[i]) apply(tbl[i]);

      // Press-to-long-press spacing measured directly on instance A.
      @(negedge clk);
      rst = 1'b0; btn_a = 1'b1; btn_b = 1'b1;
      t0 = edge_n;
      expect_ev(0, K_PUSH, t0 + 6);
      expect_ev(0, K_LONG, t0 + 22);
      wait_for("hs_push", 0, 0, 12, p_at, ok);
      if (ok) check_int("hs_push_latency", p_at - t0, 6);
      wait_for("hs_long", 0, 2, 30, l_at, ok);
      if (ok) check_int("hs_long_after_push", l_at - p_at, 16);
      @(negedge clk);
      btn_a = 1'b0;
      t1 = edge_n;
      expect_ev(0, K_REL, t1 + 6);
      wait_for("hs_release", 0, 1, 12, r_at, ok);
      if (ok) check_int("hs_release_latency", r_at - t1, 6);

      // Reset while instance B is pressed: level drops, no release follows.
      @(negedge clk);
      btn_b = 1'b0;
      t0 = edge_n;
      expect_ev(1, K_PUSH, t0 + 6);
      wait_for("hs_al_push", 1, 0, 12, p_at, ok);
      if (ok) check_int("hs_al_push_latency", p_at - t0, 6);
      @(posedge clk); #2;
      check_lvl("hs_al_level_held", lvl_b, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #2;
      check_lvl("hs_al_level_rst", lvl_b, 1'b0);
      @(negedge clk);
      rst = 1'b0; btn_b = 1'b1;
      repeat (12) @(posedge clk);
      #2;
      check_lvl("hs_al_level_idle", lvl_b, 1'b0);

      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_strobe: got none, required dut%0d %s at edge %0d",
                  e.dut, e.kind.name(), e.at);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
